// File: rtl/store_mon_pkg.sv
// rtl/store_mon_pkg.sv - shared types for the store-bus monitor
package store_mon_pkg;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_PASS = 2'd1;
  localparam logic [1:0] S_FAIL = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN  = S_RUN,
    ST_PASS = S_PASS,
    ST_FAIL = S_FAIL
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE      = 2'b00,
    FC_BAD_STORE = 2'b01,
    FC_TIMEOUT   = 2'b10
  } fail_code_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } log_entry_t;

endpackage

// File: rtl/store_monitor_if.sv
// rtl/store_monitor_if.sv - processor data-memory store bus
interface store_monitor_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;

  modport master (output MemWrite, DataAdr, WriteData);
  modport slave  (input  MemWrite, DataAdr, WriteData);
endinterface

// File: rtl/store_log_fifo.sv
// rtl/store_log_fifo.sv - first-word fall-through FIFO of logged stores
module store_log_fifo
  import store_mon_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  log_entry_t wr_entry,
  input  logic       pop,
  output log_entry_t head,
  output logic       empty,
  output logic       full,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  log_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop on the same edge frees the slot, so a push into a full log still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/store_monitor.sv
// rtl/store_monitor.sv - classifies processor stores, logs them and drives pass/fail flags
module store_monitor
  import store_mon_pkg::*;
#(
  parameter logic [31:0] PASS_ADR    = 32'd100,
  parameter logic [31:0] PASS_DATA   = 32'd7,
  parameter logic [31:0] SCRATCH_ADR = 32'd96,
  parameter int          LOG_DEPTH   = 8,
  parameter int          TIMEOUT     = 1000,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  store_monitor_if.slave   bus,
  input  logic             log_rd_en,
  output logic             log_empty,
  output logic             log_full,
  output logic [31:0]      log_addr,
  output logic [31:0]      log_data,
  output logic             overflow,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] store_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t     state;
  fail_code_t fail_code_q;
  logic       in_run, pass_store, bad_store;
  log_entry_t push_entry, head;

  assign in_run     = (state == ST_RUN);
  assign pass_store = bus.MemWrite && (bus.DataAdr == PASS_ADR) && (bus.WriteData == PASS_DATA);
  assign bad_store  = bus.MemWrite && !pass_store && (bus.DataAdr != SCRATCH_ADR);

  // Store classification outranks the watchdog on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      fail_code_q <= FC_NONE;
      cycle_cnt   <= '0;
      store_cnt   <= '0;
    end else if (in_run) begin
      if (cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + CNT_ONE;
      if (bus.MemWrite && (store_cnt != CNT_MAX)) store_cnt <= store_cnt + CNT_ONE;
      if (pass_store) begin
        state <= ST_PASS;
      end else if (bad_store) begin
        state       <= ST_FAIL;
        fail_code_q <= FC_BAD_STORE;
      end else if (cycle_cnt == TMO_LAST) begin
        state       <= ST_FAIL;
        fail_code_q <= FC_TIMEOUT;
      end
    end
  end

  assign pass      = (state == ST_PASS);
  assign fail      = (state == ST_FAIL);
  assign done      = pass | fail;
  assign fail_code = fail_code_q;

  assign push_entry.addr = bus.DataAdr;
  assign push_entry.data = bus.WriteData;

  store_log_fifo #(
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk      (clk),
    .reset    (reset),
    .push     (in_run && bus.MemWrite),
    .wr_entry (push_entry),
    .pop      (log_rd_en),
    .head     (head),
    .empty    (log_empty),
    .full     (log_full),
    .overflow (overflow)
  );

  assign log_addr = head.addr;
  assign log_data = head.data;

endmodule

// File: tb/tb_store_monitor.sv
// tb/tb_store_monitor.sv - scoreboard bench for store_monitor
module tb_store_monitor;
  import store_mon_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        log_rd_en = 1'b0;
  logic        log_empty, log_full, overflow, done, pass, fail;
  logic [31:0] log_addr, log_data;
  logic [1:0]  fail_code;
  logic [15:0] cycle_cnt, store_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  log_entry_t sb[$];

  store_monitor_if bus ();

  always #5 clk = ~clk;

  store_monitor #(
    .PASS_ADR    (32'd100),
    .PASS_DATA   (32'd7),
    .SCRATCH_ADR (32'd96),
    .LOG_DEPTH   (4),
    .TIMEOUT     (20),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .log_rd_en (log_rd_en),
    .log_empty (log_empty),
    .log_full  (log_full),
    .log_addr  (log_addr),
    .log_data  (log_data),
    .overflow  (overflow),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .fail_code (fail_code),
    .cycle_cnt (cycle_cnt),
    .store_cnt (store_cnt)
  );

  task automatic do_reset();
    reset = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit logged);
    log_entry_t e;
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = a;
    bus.WriteData = d;
    if (logged) begin
      e.addr = a;
      e.data = d;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.MemWrite = 1'b0;
  endtask

  task automatic drain(input string tag);
    log_entry_t exp;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      n_cmp++;
      if (log_empty !== 1'b0 || log_addr !== exp.addr || log_data !== exp.data) begin
        n_bad++;
        $display("FAIL %s_log_entry got empty=%b %0d/%h want 0 %0d/%h",
                 tag, log_empty, log_addr, log_data, exp.addr, exp.data);
      end
      log_rd_en = 1'b1;
      @(negedge clk);
      log_rd_en = 1'b0;
    end
    n_cmp++;
    if (log_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_log_empty got %b want 1", tag, log_empty);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({done, pass, fail, fail_code, overflow, log_empty, log_full} !== 8'b00000010 ||
        cycle_cnt !== 16'd0 || store_cnt !== 16'd0 || log_addr !== 32'd0 || log_data !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state got flags=%b cyc=%0d st=%0d log=%h/%h want 00000010 0 0 0/0",
               {done, pass, fail, fail_code, overflow, log_empty, log_full},
               cycle_cnt, store_cnt, log_addr, log_data);
    end
    reset = 1'b1;
  endtask

  task automatic test_pass();
    do_reset();
    store(32'd96, 32'h55, 1'b1);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL pass_scratch_done got %b want 0", done);
    end
    store(32'd100, 32'd7, 1'b1);
    n_cmp++;
    if ({done, pass, fail, fail_code} !== 5'b11000 || store_cnt !== 16'd2 || cycle_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL pass_flags got %b st=%0d cyc=%0d want 11000 2 2",
               {done, pass, fail, fail_code}, store_cnt, cycle_cnt);
    end
    drain("pass");
  endtask

  task automatic test_bad_store();
    do_reset();
    store(32'd100, 32'd8, 1'b1);
    n_cmp++;
    if ({done, pass, fail, fail_code} !== 5'b10101) begin
      n_bad++;
      $display("FAIL bad_flags got %b want 10101", {done, pass, fail, fail_code});
    end
    store(32'd100, 32'd7, 1'b0);
    n_cmp++;
    if ({done, pass, fail, fail_code} !== 5'b10101 || store_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL bad_terminal got %b st=%0d want 10101 1", {done, pass, fail, fail_code}, store_cnt);
    end
    drain("bad");
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (19) @(negedge clk);
    n_cmp++;
    if (fail !== 1'b0 || cycle_cnt !== 16'd19) begin
      n_bad++;
      $display("FAIL tmo_before got fail=%b cyc=%0d want 0 19", fail, cycle_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, pass, fail, fail_code} !== 5'b10110 || cycle_cnt !== 16'd20) begin
      n_bad++;
      $display("FAIL tmo_flags got %b cyc=%0d want 10110 20", {done, pass, fail, fail_code}, cycle_cnt);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (cycle_cnt !== 16'd20) begin
      n_bad++;
      $display("FAIL tmo_hold got %0d want 20", cycle_cnt);
    end
    do_reset();
    repeat (19) @(negedge clk);
    store(32'd100, 32'd7, 1'b1);
    n_cmp++;
    if ({done, pass, fail, fail_code} !== 5'b11000 || cycle_cnt !== 16'd20) begin
      n_bad++;
      $display("FAIL tmo_pass_wins got %b cyc=%0d want 11000 20", {done, pass, fail, fail_code}, cycle_cnt);
    end
    drain("tmo_pass");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) store(32'd96, 32'h10 + 32'(i), i < 4);
    n_cmp++;
    if (log_full !== 1'b1 || overflow !== 1'b1 || store_cnt !== 16'd6 || fail !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_state got full=%b ovf=%b st=%0d fail=%b want 1 1 6 0",
               log_full, overflow, store_cnt, fail);
    end
    drain("ovf");
  endtask

  task automatic test_back_to_back();
    log_entry_t exp, e;
    do_reset();
    for (int i = 0; i < 4; i++) store(32'd96, 32'hA0 + 32'(i), 1'b1);
    n_cmp++;
    if (log_full !== 1'b1 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_fill got full=%b ovf=%b want 1 0", log_full, overflow);
    end
    exp = sb.pop_front();
    n_cmp++;
    if (log_addr !== exp.addr || log_data !== exp.data) begin
      n_bad++;
      $display("FAIL b2b_head got %0d/%h want %0d/%h", log_addr, log_data, exp.addr, exp.data);
    end
    e.addr = 32'd96;
    e.data = 32'hB0;
    sb.push_back(e);
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = e.addr;
    bus.WriteData = e.data;
    log_rd_en     = 1'b1;
    @(negedge clk);
    bus.MemWrite = 1'b0;
    log_rd_en    = 1'b0;
    n_cmp++;
    if (log_full !== 1'b1 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_after got full=%b ovf=%b want 1 0", log_full, overflow);
    end
    drain("b2b");
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) store(32'd96, 32'hC0 + 32'(i), 1'b1);
    #2 reset = 1'b0;
    sb.delete();
    #1;
    n_cmp++;
    if ({done, pass, fail, fail_code, overflow, log_empty, log_full} !== 8'b00000010 ||
        cycle_cnt !== 16'd0 || store_cnt !== 16'd0 || log_addr !== 32'd0 || log_data !== 32'd0) begin
      n_bad++;
      $display("FAIL midrst_state got flags=%b cyc=%0d st=%0d log=%h/%h want 00000010 0 0 0/0",
               {done, pass, fail, fail_code, overflow, log_empty, log_full},
               cycle_cnt, store_cnt, log_addr, log_data);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (cycle_cnt !== 16'd3 || done !== 1'b0 || log_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_restart got cyc=%0d done=%b empty=%b want 3 0 1", cycle_cnt, done, log_empty);
    end
  endtask

  initial begin
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = 32'd0;
    bus.WriteData = 32'd0;
    test_reset();
    test_pass();
    test_bad_store();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
